sipo_rx_ctrl: RTL
=================

Name: sipo_rx_ctrl

Overview:
- Framing controller for a serial-in/parallel-out receive path.
- Sequences a WIDTH-bit shift register: accepts qualified serial bits after a start pulse and counts them.
- Transfers each completed word into a holding register and presents it downstream on a valid/ready handshake.
- Sits between a serial line front-end and the parallel consumer; provides busy, bit-count and sticky overrun status.

Parameters:
- WIDTH, 4, bits per word (>=2)
- CNT_W, 3, width of bit_cnt; must satisfy 2**CNT_W > WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  single-cycle pulse; begins (or restarts) a frame
- sin  input  1  serial data bit
- sin_en  input  1  sin qualifier; one bit is taken per cycle with sin_en=1 in SHIFT
- pout  output  WIDTH  received word (holding register)
- pout_valid  output  1  pout holds an unconsumed word
- pout_ready  input  1  consumer accepts pout when pout_valid=1
- busy  output  1  1 while in SHIFT
- bit_cnt  output  CNT_W  bits captured in the current frame (0..WIDTH-1)
- overrun  output  1  sticky flag: a completed word was dropped
- clr_ovr  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst=1): state=IDLE, shift reg=0, pout=0, pout_valid=0, busy=0, bit_cnt=0, overrun=0. Reset asserted mid-frame discards the partial word and any held word.
- States: IDLE, SHIFT. busy = (state==SHIFT).
- IDLE: sin/sin_en are ignored. On start=1: go to SHIFT, bit_cnt<=0. The start cycle captures no bit.
- SHIFT, sin_en=1: shift the register right with sin entering at bit WIDTH-1; the first received bit ends in bit 0.
  - bit_cnt<WIDTH-1: bit_cnt<=bit_cnt+1.
  - bit_cnt==WIDTH-1: word complete; pout load is attempted (see below); bit_cnt<=0; state<=IDLE.
- SHIFT, sin_en=0: hold all state. No timeout.
- start=1 in SHIFT: restart. bit_cnt<=0, the partial word is discarded, and any bit on sin that cycle is ignored. start has priority over sin_en.
- Word completion is the edge that samples the final qualified bit. On the next cycle, pout shows the full word (final bit in bit WIDTH-1) and pout_valid=1. Latency is 0 cycles after that edge.
- Handshake: the word transfers on the edge where pout_valid&&pout_ready. pout_valid drops after that edge unless a new word loads on the same edge.
- Load rule at completion:
  - pout_valid=0: load.
  - pout_valid=1 and pout_ready=1: load; pout_valid stays 1 with the new data.
  - pout_valid=1 and pout_ready=0: new word dropped, pout and pout_valid unchanged, overrun<=1.
- pout is stable while pout_valid=1 and the word is unaccepted. pout_ready is ignored when pout_valid=0.
- overrun is sticky. clr_ovr=1 clears it next edge. If a set and clr_ovr coincide, set wins.
- Frames are back-to-back capable: a new start may arrive in the cycle right after completion. Capture continues regardless of pout_valid.

Test Plan:
- WIDTH=4. rst pulse, then start; sin=1,0,1,1 on 4 consecutive sin_en cycles, pout_ready=1 -> pout=4'b1101 and pout_valid=1 for exactly 1 cycle after the 4th bit edge; busy=0, bit_cnt=0 afterwards.
- Gapped sin_en (bit, 2 idle cycles, bit, bit, idle, bit) with sin=0,1,1,0 -> bit_cnt steps 0,1,2,3 and holds during gaps; pout=4'b0110.
- pout_ready=0; two frames 1,1,1,1 then 0,0,0,0 -> pout stays 4'b1111, overrun=1. Then pout_ready=1 for 1 cycle -> pout_valid=0. Then clr_ovr=1 -> overrun=0.
- Restart: start, bits 1,1, start again, bits 0,1,0,1 -> pout=4'b1010 and the first partial bits are lost. Also check start coinciding with sin_en -> that bit is not captured.
- Word completes on the same edge that an old word is accepted (pout_ready=1) -> pout_valid stays 1, pout updates to the new word, overrun stays 0.
- rst asserted asynchronously mid-frame (bit_cnt=2) with pout_valid=1 -> all outputs 0 immediately, before the next clk edge; IDLE after release.

Source files
------------

// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: framing controller for a serial-in/parallel-out receive path.
// A start pulse opens a frame. WIDTH qualified serial bits are then shifted in,
// LSB first. The completed word moves into a holding register and is offered
// downstream on a valid/ready handshake. A word that completes while the
// holding register is still owned by the consumer is dropped, and this sets a
// sticky overrun flag.

module sipo_rx_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       SHIFT    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

  // Registered state
  logic [0:0]       state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [WIDTH-1:0] pout_r;
  logic             pout_valid_r;
  logic             busy_r;
  logic             overrun_r;

  // Next-state values
  logic [0:0]       state_s;
  logic [WIDTH-1:0] shreg_s;
  logic [CNT_W-1:0] bit_cnt_s;
  logic [WIDTH-1:0] word_s;
  logic             complete_s;
  logic             accept_s;
  logic             load_s;
  logic             drop_s;
  logic [WIDTH-1:0] pout_s;
  logic             pout_valid_s;
  logic             overrun_s;

  // Frame sequencing: start, per-bit shift/count, and word completion.
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    bit_cnt_s  = bit_cnt_r;
    complete_s = 1'b0;
    // New bit enters at the MSB, so the first bit ends up in bit 0.
    word_s     = {sin, shreg_r[WIDTH-1:1]};
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = SHIFT;
          bit_cnt_s = CNT_ZERO;
          shreg_s   = WORD_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (start) begin
          // Restart. The partial word is discarded and this cycle's bit is ignored.
          bit_cnt_s = CNT_ZERO;
          shreg_s   = WORD_ZERO;
        end else if (sin_en) begin
          shreg_s = word_s;
          if (bit_cnt_r == LAST_BIT) begin
            complete_s = 1'b1;
            bit_cnt_s  = CNT_ZERO;
            state_s    = IDLE;
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_ONE;
          end
        end else begin
          // No qualified bit this cycle. Wait indefinitely.
          state_s = SHIFT;
        end
      end
      default: begin
        state_s   = IDLE;
        bit_cnt_s = CNT_ZERO;
        shreg_s   = WORD_ZERO;
      end
    endcase
  end

  // Holding register, handshake and overrun bookkeeping.
  always_comb begin
    accept_s     = pout_valid_r & pout_ready;
    load_s       = complete_s & (~pout_valid_r | pout_ready);
    drop_s       = complete_s & pout_valid_r & ~pout_ready;
    pout_s       = pout_r;
    pout_valid_s = pout_valid_r;
    if (load_s) begin
      // Covers an empty holding register and a same-edge accept-and-replace.
      pout_s       = word_s;
      pout_valid_s = 1'b1;
    end else if (accept_s) begin
      pout_valid_s = 1'b0;
    end else begin
      pout_valid_s = pout_valid_r;
    end
    // A set takes priority over a clear on the same edge.
    if (drop_s) begin
      overrun_s = 1'b1;
    end else if (clr_ovr) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // State and output registers. Reset discards any partial or held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      shreg_r      <= WORD_ZERO;
      bit_cnt_r    <= CNT_ZERO;
      pout_r       <= WORD_ZERO;
      pout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      bit_cnt_r    <= bit_cnt_s;
      pout_r       <= pout_s;
      pout_valid_r <= pout_valid_s;
      busy_r       <= (state_s == SHIFT);
      overrun_r    <= overrun_s;
    end
  end

  assign pout       = pout_r;
  assign pout_valid = pout_valid_r;
  assign busy       = busy_r;
  assign bit_cnt    = bit_cnt_r;
  assign overrun    = overrun_r;

  sipo_rx_ctrl_chk #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .pout       (pout_r),
    .pout_valid (pout_valid_r),
    .pout_ready (pout_ready),
    .busy       (busy_r),
    .bit_cnt    (bit_cnt_r)
  );

endmodule

// Protocol invariants of the receive controller, observed on its outputs.
module sipo_rx_ctrl_chk #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] pout,
  input logic             pout_valid,
  input logic             pout_ready,
  input logic             busy,
  input logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // bit_cnt never leaves 0..WIDTH-1.
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    bit_cnt <= LAST_BIT);

  // Outside a frame the bit count is zero.
  a_idle_cnt: assert property (@(posedge clk) disable iff (rst)
    !busy |-> bit_cnt == {CNT_W{1'b0}});

  // An offered word that has not been accepted stays put.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (pout_valid && !pout_ready) |=> (pout_valid && $stable(pout)));

endmodule
